multicycle_sequencer: RTL and testbench

- Parametrised control sequencer for the multi-cycle RV32I core; replaces the fixed single-cycle-memory FSM in the core top.
- Sequences FETCH_ADDR → FETCH_WAIT → DECODE → EXECUTE → MEMORY_ADDR → MEMORY_WAIT → WRITEBACK.
- Adds variable-latency ready/error handshakes on instruction and data memory, a bus timeout, trap sequencing, debug halt, and cycle/instret counters.
- Drives the one-hot stage enables consumed by the pc_update, fetch, decode, execute, memory and writeback stages.

---
 rtl/multicycle_sequencer_pkg.sv | 39 +++
 rtl/multicycle_sequencer_if.sv | 57 +++++
 rtl/multicycle_sequencer_wait_timeout_counter.sv | 53 +++++
 rtl/multicycle_sequencer.sv | 168 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_sequencer_pkg
// Brief   : Shared FSM state codes, memory-op type and trap causes.
// Revision: 1.0
// ============================================================================
package multicycle_sequencer_pkg;

    typedef logic [3:0] fsm_state_op_t;

    localparam logic [3:0] FETCH_ADDR  = 4'd0;
    localparam logic [3:0] FETCH_WAIT  = 4'd1;
    localparam logic [3:0] DECODE      = 4'd2;
    localparam logic [3:0] EXECUTE     = 4'd3;
    localparam logic [3:0] MEMORY_ADDR = 4'd4;
    localparam logic [3:0] MEMORY_WAIT = 4'd5;
    localparam logic [3:0] WRITEBACK   = 4'd6;
    localparam logic [3:0] TRAP        = 4'd7;
    localparam logic [3:0] HALT        = 4'd8;

    typedef enum logic [1:0] {
        MEM_SKIP_OP  = 2'd0,
        MEM_LOAD_OP  = 2'd1,
        MEM_STORE_OP = 2'd2
    } mem_op_t;

    localparam logic [3:0] CAUSE_IFETCH_FAULT = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
    localparam logic [3:0] CAUSE_LD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT     = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN  = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT     = 4'd7;

    function automatic logic is_wait_state(input fsm_state_op_t s);
        return (s == FETCH_WAIT) || (s == MEMORY_WAIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_sequencer_if
// Brief   : Decoder/memory status inputs and stage-control outputs of the sequencer.
// Revision: 1.0
// ============================================================================
interface multicycle_sequencer_if #(
    parameter int CNT_WIDTH = 64
);
    import multicycle_sequencer_pkg::*;

    logic                 dec_alu_used;
    mem_op_t              dec_mem_op;
    logic                 dec_writeback;
    logic                 dec_illegal;
    logic                 mem_misaligned;
    logic                 imem_ready;
    logic                 imem_err;
    logic                 dmem_ready;
    logic                 dmem_err;
    logic                 halt_req;

    logic                 pc_update_en;
    logic                 fetch_en;
    logic                 decode_en;
    logic                 execute_en;
    logic                 mem_addr_en;
    logic                 mem_wait_en;
    logic                 writeback_en;
    logic                 imem_req;
    logic                 dmem_req;
    logic                 dmem_we;
    logic                 retire;
    logic                 trap_valid;
    logic [3:0]           trap_cause;
    logic                 halted;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic [CNT_WIDTH-1:0] instret_count;

    modport master (
        input  dec_alu_used, dec_mem_op, dec_writeback, dec_illegal, mem_misaligned,
        input  imem_ready, imem_err, dmem_ready, dmem_err, halt_req,
        output pc_update_en, fetch_en, decode_en, execute_en, mem_addr_en,
        output mem_wait_en, writeback_en, imem_req, dmem_req, dmem_we,
        output retire, trap_valid, trap_cause, halted, cycle_count, instret_count
    );

    modport slave (
        output dec_alu_used, dec_mem_op, dec_writeback, dec_illegal, mem_misaligned,
        output imem_ready, imem_err, dmem_ready, dmem_err, halt_req,
        input  pc_update_en, fetch_en, decode_en, execute_en, mem_addr_en,
        input  mem_wait_en, writeback_en, imem_req, dmem_req, dmem_we,
        input  retire, trap_valid, trap_cause, halted, cycle_count, instret_count
    );

endinterface
`default_nettype wire

// File: rtl/multicycle_sequencer_wait_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module  : wait_timeout_counter
// Brief   : Counts memory wait cycles; expired marks the MEM_TIMEOUT-th one.
// Revision: 1.0
// ============================================================================
module wait_timeout_counter #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_WIDTH    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1
) (
    input  wire  clock,
    input  wire  reset,
    input  wire  clear,
    input  wire  en,
    output logic expired
);

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam logic [TO_WIDTH-1:0] c_LIMIT = TO_WIDTH'(MEM_TIMEOUT - 1);
            localparam logic [TO_WIDTH-1:0] c_ONE   = TO_WIDTH'(1);

            logic [TO_WIDTH-1:0] count_q;
            logic [TO_WIDTH-1:0] count_d;

            // Saturate at the limit; the FSM leaves the wait state on that cycle anyway.
            always_comb begin
                count_d = count_q;
                if (clear) begin
                    count_d = '0;
                end else if (en && (count_q != c_LIMIT)) begin
                    count_d = count_q + c_ONE;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired = en && (count_q == c_LIMIT);
        end else begin : g_no_timeout
            logic unused_inputs;
            assign unused_inputs = clock ^ reset ^ clear ^ en;
            assign expired       = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_sequencer
// Brief   : Multi-cycle RV32I control FSM with memory handshakes, traps and halt.
// Revision: 1.0
// ============================================================================
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 64,
    parameter int TO_WIDTH    = $clog2(MEM_TIMEOUT + 1)
) (
    input  wire                    clock,
    input  wire                    reset,
    multicycle_sequencer_if.master bus
);
    import multicycle_sequencer_pkg::*;

    localparam int                   c_TO_W = (TO_WIDTH < 1) ? 1 : TO_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_ONE  = CNT_WIDTH'(1);

    fsm_state_op_t        state_q;
    fsm_state_op_t        state_d;
    logic [3:0]           cause_q;
    logic [3:0]           cause_d;
    mem_op_t              op_q;
    logic                 wb_q;
    logic                 retire_q;
    logic                 retire_d;
    logic [CNT_WIDTH-1:0] cycle_q;
    logic [CNT_WIDTH-1:0] instret_q;

    logic                 w_in_wait;
    logic                 w_expired;
    logic                 w_run;
    logic                 w_is_load;

    assign w_in_wait = is_wait_state(state_q);
    assign w_is_load = (op_q == MEM_LOAD_OP);

    wait_timeout_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_WIDTH    (c_TO_W)
    ) u_wait_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (!w_in_wait),
        .en      (w_in_wait),
        .expired (w_expired)
    );

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        retire_d = 1'b0;
        case (state_q)
            FETCH_ADDR: begin
                state_d = bus.halt_req ? HALT : FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (bus.imem_err || (w_expired && !bus.imem_ready)) begin
                    state_d = TRAP;
                    cause_d = CAUSE_IFETCH_FAULT;
                end else if (bus.imem_ready) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (bus.dec_illegal) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (bus.dec_alu_used) begin
                    state_d = EXECUTE;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            EXECUTE: begin
                if ((op_q != MEM_SKIP_OP) && bus.mem_misaligned) begin
                    state_d = TRAP;
                    cause_d = w_is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
                end else if (op_q != MEM_SKIP_OP) begin
                    state_d = MEMORY_ADDR;
                end else if (wb_q) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d  = FETCH_ADDR;
                    retire_d = 1'b1;
                end
            end
            MEMORY_ADDR: begin
                state_d = MEMORY_WAIT;
            end
            MEMORY_WAIT: begin
                if (bus.dmem_err || (w_expired && !bus.dmem_ready)) begin
                    state_d = TRAP;
                    cause_d = w_is_load ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
                end else if (bus.dmem_ready && w_is_load) begin
                    state_d = WRITEBACK;
                end else if (bus.dmem_ready) begin
                    state_d  = FETCH_ADDR;
                    retire_d = 1'b1;
                end
            end
            WRITEBACK: begin
                state_d  = FETCH_ADDR;
                retire_d = 1'b1;
            end
            TRAP: begin
                state_d = FETCH_ADDR;
            end
            HALT: begin
                if (!bus.halt_req) begin
                    state_d = FETCH_ADDR;
                end
            end
            default: begin
                state_d = FETCH_ADDR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH_ADDR;
            cause_q   <= 4'd0;
            op_q      <= MEM_SKIP_OP;
            wb_q      <= 1'b0;
            retire_q  <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            retire_q <= retire_d;
            cycle_q  <= cycle_q + c_ONE;
            if (retire_d) begin
                instret_q <= instret_q + c_ONE;
            end
            // Decoder fields stay frozen from DECODE until the next instruction's DECODE.
            if (state_q == DECODE) begin
                op_q <= bus.dec_mem_op;
                wb_q <= bus.dec_writeback;
            end
        end
    end

    // Reset masks the state decode so every control output is low while it is held.
    assign w_run = !reset;

    assign bus.pc_update_en  = w_run && (state_q == FETCH_ADDR);
    assign bus.fetch_en      = w_run && (state_q == FETCH_WAIT);
    assign bus.decode_en     = w_run && (state_q == DECODE);
    assign bus.execute_en    = w_run && (state_q == EXECUTE);
    assign bus.mem_addr_en   = w_run && (state_q == MEMORY_ADDR);
    assign bus.mem_wait_en   = w_run && (state_q == MEMORY_WAIT);
    assign bus.writeback_en  = w_run && (state_q == WRITEBACK);
    assign bus.imem_req      = w_run && (state_q == FETCH_WAIT);
    assign bus.dmem_req      = w_run && (state_q == MEMORY_WAIT);
    assign bus.dmem_we       = w_run && (state_q == MEMORY_WAIT) && (op_q == MEM_STORE_OP);
    assign bus.trap_valid    = w_run && (state_q == TRAP);
    assign bus.halted        = w_run && (state_q == HALT);
    assign bus.retire        = w_run && retire_q;
    assign bus.trap_cause    = w_run ? cause_q : 4'd0;
    assign bus.cycle_count   = w_run ? cycle_q : '0;
    assign bus.instret_count = w_run ? instret_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_sequencer
// Brief   : Directed self-checking bench for multicycle_sequencer.
// Revision: 1.0
// ============================================================================
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    localparam logic [6:0] EN_NONE = 7'b0000000;
    localparam logic [6:0] EN_FA   = 7'b1000000;
    localparam logic [6:0] EN_FW   = 7'b0100000;
    localparam logic [6:0] EN_DE   = 7'b0010000;
    localparam logic [6:0] EN_EX   = 7'b0001000;
    localparam logic [6:0] EN_MA   = 7'b0000100;
    localparam logic [6:0] EN_MW   = 7'b0000010;
    localparam logic [6:0] EN_WB   = 7'b0000001;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   ncyc;

    multicycle_sequencer_if #(.CNT_WIDTH(32)) bus_a ();
    multicycle_sequencer_if #(.CNT_WIDTH(4))  bus_w ();

    multicycle_sequencer #(
        .MEM_TIMEOUT (4),
        .CNT_WIDTH   (32)
    ) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_a)
    );

    multicycle_sequencer #(
        .CNT_WIDTH (4)
    ) u_dut_wrap (
        .clock (clk),
        .reset (rst),
        .bus   (bus_w)
    );

    logic [6:0] w_en_a;
    assign w_en_a = {bus_a.pc_update_en, bus_a.fetch_en, bus_a.decode_en, bus_a.execute_en,
                     bus_a.mem_addr_en, bus_a.mem_wait_en, bus_a.writeback_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) ncyc = 0;
        else     ncyc++;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ncyc  = 0;
        rst   = 1'b1;
        bus_a.dec_alu_used = 1'b0; bus_a.dec_mem_op = MEM_SKIP_OP; bus_a.dec_writeback = 1'b0;
        bus_a.dec_illegal = 1'b0; bus_a.mem_misaligned = 1'b0; bus_a.imem_ready = 1'b0;
        bus_a.imem_err = 1'b0; bus_a.dmem_ready = 1'b0; bus_a.dmem_err = 1'b0; bus_a.halt_req = 1'b0;
        bus_w.dec_alu_used = 1'b0; bus_w.dec_mem_op = MEM_SKIP_OP; bus_w.dec_writeback = 1'b0;
        bus_w.dec_illegal = 1'b0; bus_w.mem_misaligned = 1'b0; bus_w.imem_ready = 1'b0;
        bus_w.imem_err = 1'b0; bus_w.dmem_ready = 1'b0; bus_w.dmem_err = 1'b0; bus_w.halt_req = 1'b0;

        // Reset state
        step(); step();
        chk("rst_en", w_en_a, EN_NONE);
        chk("rst_cycle", bus_a.cycle_count, 0);
        chk("rst_instret", bus_a.instret_count, 0);
        chk("rst_retire", bus_a.retire, 0);
        chk("rst_trap", bus_a.trap_valid, 0);
        chk("rst_halted", bus_a.halted, 0);
        chk("rst_imem_req", bus_a.imem_req, 0);
        rst = 1'b0;
        #1;
        chk("fa0_en", w_en_a, EN_FA);
        chk("fa0_cycle", bus_a.cycle_count, 0);

        // ALU instruction with writeback
        bus_a.imem_ready = 1'b1; bus_a.dec_alu_used = 1'b1;
        bus_a.dec_mem_op = MEM_SKIP_OP; bus_a.dec_writeback = 1'b1;
        step(); chk("alu_fw", w_en_a, EN_FW); chk("alu_imem_req", bus_a.imem_req, 1);
        step(); chk("alu_de", w_en_a, EN_DE);
        step(); chk("alu_ex", w_en_a, EN_EX);
        step(); chk("alu_wb", w_en_a, EN_WB); chk("alu_wb_retire", bus_a.retire, 0);
        step(); chk("alu_fa", w_en_a, EN_FA); chk("alu_retire", bus_a.retire, 1);
        chk("alu_instret", bus_a.instret_count, 1);
        chk("alu_cycle", bus_a.cycle_count, 5);
        chk("wrap_dut_cycle5", bus_w.cycle_count, 5);

        // Load, dmem_ready on the third wait cycle
        bus_a.dec_mem_op = MEM_LOAD_OP;
        step(); step();
        step(); chk("ld_ex", w_en_a, EN_EX); chk("ld_retire_low", bus_a.retire, 0);
        step(); chk("ld_ma", w_en_a, EN_MA); chk("ld_ma_dmem_req", bus_a.dmem_req, 0);
        step(); chk("ld_mw1", w_en_a, EN_MW); chk("ld_mw1_req", bus_a.dmem_req, 1);
        chk("ld_mw1_we", bus_a.dmem_we, 0);
        step(); chk("ld_mw2", w_en_a, EN_MW);
        step(); chk("ld_mw3", w_en_a, EN_MW);
        bus_a.dmem_ready = 1'b1;
        step(); chk("ld_wb", w_en_a, EN_WB);
        bus_a.dmem_ready = 1'b0;
        step(); chk("ld_fa", w_en_a, EN_FA); chk("ld_retire", bus_a.retire, 1);
        chk("ld_instret", bus_a.instret_count, 2);

        // Store, same timing: no writeback
        bus_a.dec_mem_op = MEM_STORE_OP; bus_a.dec_writeback = 1'b0;
        step(); step(); step(); step();
        step(); chk("st_mw1", w_en_a, EN_MW); chk("st_mw1_we", bus_a.dmem_we, 1);
        step(); chk("st_mw2_we", bus_a.dmem_we, 1);
        step(); chk("st_mw3", w_en_a, EN_MW); chk("st_mw3_we", bus_a.dmem_we, 1);
        bus_a.dmem_ready = 1'b1;
        step(); chk("st_fa", w_en_a, EN_FA); chk("st_retire", bus_a.retire, 1);
        chk("st_instret", bus_a.instret_count, 3);
        bus_a.dmem_ready = 1'b0;

        // Fetch timeout after exactly 4 wait cycles
        bus_a.imem_ready = 1'b0; bus_a.dec_mem_op = MEM_SKIP_OP;
        for (int i = 0; i < 4; i++) begin
            step(); chk("to_fw", w_en_a, EN_FW); chk("to_no_trap", bus_a.trap_valid, 0);
        end
        step(); chk("to_trap", bus_a.trap_valid, 1); chk("to_cause", bus_a.trap_cause, 1);
        chk("to_en_none", w_en_a, EN_NONE); chk("to_instret", bus_a.instret_count, 3);
        step(); chk("to_fa", w_en_a, EN_FA); chk("to_trap_low", bus_a.trap_valid, 0);
        chk("to_cause_hold", bus_a.trap_cause, 1); chk("to_no_retire", bus_a.retire, 0);

        // Illegal instruction
        bus_a.imem_ready = 1'b1; bus_a.dec_illegal = 1'b1;
        step(); step();
        step(); chk("ill_trap", bus_a.trap_valid, 1); chk("ill_cause", bus_a.trap_cause, 2);
        bus_a.dec_illegal = 1'b0;
        step();

        // Fetch error together with ready: error wins
        bus_a.imem_err = 1'b1;
        step(); chk("ierr_fw", w_en_a, EN_FW);
        step(); chk("ierr_trap", bus_a.trap_valid, 1); chk("ierr_cause", bus_a.trap_cause, 1);
        bus_a.imem_err = 1'b0;
        step(); chk("ierr_instret", bus_a.instret_count, 3);

        // Misaligned store
        bus_a.dec_mem_op = MEM_STORE_OP; bus_a.mem_misaligned = 1'b1;
        step(); step();
        step(); chk("mis_ex", w_en_a, EN_EX);
        step(); chk("mis_trap", bus_a.trap_valid, 1); chk("mis_cause", bus_a.trap_cause, 6);
        chk("mis_no_dmem_req", bus_a.dmem_req, 0);
        bus_a.mem_misaligned = 1'b0;
        step(); chk("mis_instret", bus_a.instret_count, 3);

        // Halt raised mid-EXECUTE of a load
        bus_a.dec_mem_op = MEM_LOAD_OP; bus_a.dec_writeback = 1'b1;
        step(); step(); step();
        bus_a.halt_req = 1'b1;
        step(); chk("hlt_ma", w_en_a, EN_MA);
        step(); chk("hlt_mw", w_en_a, EN_MW);
        bus_a.dmem_ready = 1'b1;
        step(); chk("hlt_wb", w_en_a, EN_WB);
        bus_a.dmem_ready = 1'b0;
        step(); chk("hlt_fa", w_en_a, EN_FA); chk("hlt_retire", bus_a.retire, 1);
        chk("hlt_instret", bus_a.instret_count, 4);
        step(); chk("hlt_halted", bus_a.halted, 1); chk("hlt_en_none", w_en_a, EN_NONE);
        step(); chk("hlt_still", bus_a.halted, 1); chk("hlt_cycle", bus_a.cycle_count, 64'(ncyc));
        bus_a.halt_req = 1'b0;
        step(); chk("hlt_exit_fa", w_en_a, EN_FA); chk("hlt_exit_halted", bus_a.halted, 0);

        // Reset during MEMORY_WAIT
        step(); step(); step(); step();
        step(); chk("rmw_req", bus_a.dmem_req, 1);
        rst = 1'b1;
        step(); chk("rmw_req_drop", bus_a.dmem_req, 0);
        chk("rmw_cycle", bus_a.cycle_count, 0); chk("rmw_instret", bus_a.instret_count, 0);
        rst = 1'b0;
        #1;
        chk("rmw_fa", w_en_a, EN_FA);

        // 17 cycles: 4-bit counter wraps to 1
        bus_a.imem_ready = 1'b0;
        repeat (17) step();
        chk("wrap_a_cycle", bus_a.cycle_count, 17);
        chk("wrap_w_cycle", bus_w.cycle_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
